// File: rtl/enigma_feeder.sv
// Host-side initiator for the Enigma core: one character in flight, output FIFO.
// Define ENIGMA_FEEDER_FILTER_EN to fold lowercase and bypass non-letters.
module enigma_feeder #(
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_start,
    input  logic       cfg_dec,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       core_set,
    output logic       core_en,
    output logic       core_valid,
    output logic [7:0] core_din,
    output logic       core_dec,
    input  logic       core_done,
    input  logic [7:0] core_dout,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d;
    logic          byp_q, byp_d;
    logic          dec_q, dec_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [8:0]    mem_q [OUT_DEPTH];

    logic       hs, push, pop;
    logic [8:0] push_data;
    logic [7:0] in_byte;
    logic       in_byp;

    always_comb begin
        in_byte = in_data;
        in_byp  = 1'b0;
`ifdef ENIGMA_FEEDER_FILTER_EN
        if (in_data >= 8'h61 && in_data <= 8'h7a) begin
            in_byte = in_data - 8'h20;
        end else if (!(in_data >= 8'h41 && in_data <= 8'h5a)) begin
            in_byp = 1'b1;
        end
`endif
    end

    assign in_ready   = (state_q == S_LOAD) && (cnt_q < CW'(OUT_DEPTH));
    assign core_set   = (state_q == S_SET);
    assign core_en    = (state_q == S_SET) || (state_q == S_LOAD) ||
                        (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign core_valid = (state_q == S_ISSUE) && !byp_q;
    assign core_din   = byte_q;
    assign core_dec   = dec_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_ERR);
    assign err        = err_q;
    assign out_valid  = (cnt_q != '0);
    assign out_data   = out_valid ? mem_q[rd_q][8:1] : 8'h00;
    assign out_last   = out_valid ? mem_q[rd_q][0] : 1'b0;

    assign hs  = in_ready && in_valid;
    assign pop = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        last_d    = last_q;
        byp_d     = byp_q;
        dec_d     = dec_q;
        err_d     = err_q;
        tmr_d     = tmr_q;
        push      = 1'b0;
        push_data = {core_dout, last_q};
        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (cfg_start) begin
                    dec_d   = cfg_dec;
                    err_d   = 1'b0;
                    state_d = S_SET;
                end
            end
            S_SET: state_d = S_LOAD;
            S_LOAD: begin
                if (hs) begin
                    byte_d  = in_byte;
                    last_d  = in_last;
                    byp_d   = in_byp;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d = '0;
                // Bypassed bytes go straight to the FIFO instead of the core
                if (byp_q) begin
                    push      = 1'b1;
                    push_data = {byte_q, last_q};
                    state_d   = last_q ? S_IDLE : S_LOAD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (core_done) begin
                    push    = 1'b1;
                    state_d = last_q ? S_IDLE : S_LOAD;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            last_q  <= 1'b0;
            byp_q   <= 1'b0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            byp_q   <= byp_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_q + CW'(push) - CW'(pop);
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: tb/tb_enigma_feeder.sv
// Directed bench for enigma_feeder with a fixed-latency core model (din+1).
module tb_enigma_feeder;
    logic       clk, reset, cfg_start, cfg_dec;
    logic       in_valid, in_last, in_ready;
    logic [7:0] in_data;
    logic       core_set, core_en, core_valid, core_dec;
    logic [7:0] core_din;
    logic       core_done;
    logic [7:0] core_dout;
    logic       out_valid, out_last, out_ready, busy, err;
    logic [7:0] out_data;

    int n_chk = 0;
    int n_fail = 0;

    enigma_feeder #(.OUT_DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_dec(cfg_dec),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .core_set(core_set), .core_en(core_en),
        .core_valid(core_valid), .core_din(core_din), .core_dec(core_dec),
        .core_done(core_done), .core_dout(core_dout),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: answers din+1 five cycles after core_valid when enabled
    logic       core_on = 1'b1;
    logic       c_act = 1'b0;
    int         c_cnt = 0;
    logic [7:0] c_q = 8'h00;
    int         nset = 0, ncv = 0, nout = 0;
    logic [8:0] olog [64];
    logic [7:0] clog [64];

    initial begin
        core_done = 1'b0;
        core_dout = 8'h00;
    end

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_valid && core_on && !c_act) begin
            c_act <= 1'b1;
            c_cnt <= 5;
            c_q   <= core_din + 8'h01;
        end else if (c_act) begin
            if (c_cnt == 1) begin
                core_done <= 1'b1;
                core_dout <= c_q;
                c_act     <= 1'b0;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end
        if (core_set) nset <= nset + 1;
        if (core_valid) begin
            clog[ncv % 64] <= core_din;
            ncv <= ncv + 1;
        end
        if (out_valid && out_ready) begin
            olog[nout % 64] <= {out_data, out_last};
            nout <= nout + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic d);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_dec   = d;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int n;
        n = 0;
        while (nout < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("out_timeout", nout, target);
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    int b_set, b_cv, b_out;
    logic [7:0] msg [6];

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_dec = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        msg[0] = "A"; msg[1] = "B"; msg[2] = "C";
        msg[3] = "D"; msg[4] = "E"; msg[5] = "F";
        cycles(2);
        reset = 1'b0;
        @(negedge clk);
        check("reset_outs", {in_ready, core_set, core_en, core_valid, core_din,
                             core_dec, out_valid, out_data, out_last, busy, err}, 0);
        check("reset_busy", busy, 0);
        check("reset_empty", out_valid, 0);

        // Decrypt "AB"
        b_set = nset; b_cv = ncv; b_out = nout;
        @(negedge clk);
        cfg_start = 1'b1; cfg_dec = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("set_t1", core_set, 1);
        @(negedge clk);
        check("ready_t2", in_ready, 1);
        check("dec_latched", core_dec, 1);
        send("A", 1'b0);
        send("B", 1'b1);
        wait_out(b_out + 2);
        cycles(2);
        check("ab_nset", nset - b_set, 1);
        check("ab_ncv", ncv - b_cv, 2);
        check("ab_out0", olog[b_out % 64], {8'h42, 1'b0});
        check("ab_out1", olog[(b_out + 1) % 64], {8'h43, 1'b1});
        check("ab_busy", busy, 0);

        // Backpressure with a 6-char message
        out_ready = 1'b0;
        b_cv = ncv; b_out = nout;
        start(1'b0);
        fork
            begin
                for (int i = 0; i < 6; i++) send(msg[i], i == 5);
            end
            begin
                cycles(200);
                check("bp_ncv", ncv - b_cv, 4);
                check("bp_ready", in_ready, 0);
                check("bp_nout", nout - b_out, 0);
                out_ready = 1'b1;
            end
        join
        wait_out(b_out + 6);
        for (int i = 0; i < 6; i++)
            check("bp_data", olog[(b_out + i) % 64], {msg[i] + 8'h01, i == 5});
        cycles(2);

        // Core never answers
        core_on = 1'b0;
        start(1'b0);
        send("X", 1'b1);
        cycles(60);
        check("to_early", err, 0);
        cycles(10);
        check("to_err", err, 1);
        check("to_en", core_en, 0);
        check("to_busy", busy, 0);
        core_on = 1'b1;
        b_set = nset; b_out = nout;
        start(1'b0);
        check("rs_err", err, 0);
        check("rs_set", core_set, 1);
        send("Q", 1'b1);
        wait_out(b_out + 1);
        check("rs_nset", nset - b_set, 1);
        check("rs_out", olog[b_out % 64], {8'h52, 1'b1});
        cycles(2);

`ifdef ENIGMA_FEEDER_FILTER_EN
        b_cv = ncv; b_out = nout;
        start(1'b0);
        send("a", 1'b0);
        send("1", 1'b1);
        wait_out(b_out + 2);
        cycles(2);
        check("flt_ncv", ncv - b_cv, 1);
        check("flt_din", clog[b_cv % 64], 8'h41);
        check("flt_out0", olog[b_out % 64], {8'h42, 1'b0});
        check("flt_out1", olog[(b_out + 1) % 64], {8'h31, 1'b1});
`endif

        // Reset mid-WAIT, core answers afterwards
        b_out = nout;
        start(1'b0);
        send("M", 1'b1);
        cycles(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cycles(10);
        check("rst_ovalid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_nout", nout - b_out, 0);
        check("rst_en", core_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
